mips_mem_wb_stage: RTL and testbench



---
 rtl/mips_pkg.sv | 47 ++++
 rtl/mips_regfile.sv | 56 +++++
 rtl/mips_mem_wb_stage.sv | 137 +++++++++++++
 tb/tb_mips_mem_wb_stage.sv | 317 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared constants and decode helpers for the pipe_MIPS32 back end.
// Covers opcodes, instruction classes and destination-register selection.
package mips_pkg;

    localparam logic [5:0] OP_ADD   = 6'b000000;
    localparam logic [5:0] OP_SUB   = 6'b000001;
    localparam logic [5:0] OP_AND   = 6'b000010;
    localparam logic [5:0] OP_OR    = 6'b000011;
    localparam logic [5:0] OP_SLT   = 6'b000100;
    localparam logic [5:0] OP_MUL   = 6'b000101;
    localparam logic [5:0] OP_LW    = 6'b001000;
    localparam logic [5:0] OP_SW    = 6'b001001;
    localparam logic [5:0] OP_ADDI  = 6'b001010;
    localparam logic [5:0] OP_SUBI  = 6'b001011;
    localparam logic [5:0] OP_SLTI  = 6'b001100;
    localparam logic [5:0] OP_BNEQZ = 6'b001101;
    localparam logic [5:0] OP_BEQZ  = 6'b001110;
    localparam logic [5:0] OP_HLT   = 6'b111111;

    localparam logic [2:0] TYPE_RR_ALU = 3'b000;
    localparam logic [2:0] TYPE_RM_ALU = 3'b001;
    localparam logic [2:0] TYPE_LOAD   = 3'b010;
    localparam logic [2:0] TYPE_STORE  = 3'b011;
    localparam logic [2:0] TYPE_BRANCH = 3'b100;
    localparam logic [2:0] TYPE_HALT   = 3'b101;

    // The two unused encodings above HALT are folded into HALT.
    function automatic logic is_halt(input logic [2:0] typ);
        return (typ >= TYPE_HALT);
    endfunction

    function automatic logic writes_reg(input logic [2:0] typ);
        return (typ == TYPE_RR_ALU) || (typ == TYPE_RM_ALU) || (typ == TYPE_LOAD);
    endfunction

    function automatic logic [4:0] dest_reg(input logic [2:0] typ, input logic [31:0] ir);
        logic [4:0] rd;
        case (typ)
            TYPE_RR_ALU: rd = ir[15:11];
            TYPE_RM_ALU: rd = ir[20:16];
            TYPE_LOAD:   rd = ir[20:16];
            default:     rd = 5'd0;
        endcase
        return rd;
    endfunction

endpackage

// File: rtl/mips_regfile.sv
// 32x32 register bank: one write port, two combinational read ports.
// r0 reads as zero; reads bypass a same-cycle write to the same register.
module mips_regfile
    import mips_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        we,
    input  logic [4:0]  waddr,
    input  logic [31:0] wdata,
    input  logic [4:0]  raddr_a,
    output logic [31:0] rdata_a,
    input  logic [4:0]  raddr_b,
    output logic [31:0] rdata_b
);

    logic [31:0] regs_r [32];

    // Register storage with asynchronous clear; r0 is never written.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 32; i++) begin
                regs_r[i] <= 32'd0;
            end
        end else begin
            if (we && (waddr != 5'd0)) begin
                regs_r[waddr] <= wdata;
            end
        end
    end

    // Read port A with zero-register and write-bypass handling.
    always_comb begin
        rdata_a = 32'd0;
        if (raddr_a == 5'd0) begin
            rdata_a = 32'd0;
        end else if (we && (waddr == raddr_a)) begin
            rdata_a = wdata;
        end else begin
            rdata_a = regs_r[raddr_a];
        end
    end

    // Read port B with zero-register and write-bypass handling.
    always_comb begin
        rdata_b = 32'd0;
        if (raddr_b == 5'd0) begin
            rdata_b = 32'd0;
        end else if (we && (waddr == raddr_b)) begin
            rdata_b = wdata;
        end else begin
            rdata_b = regs_r[raddr_b];
        end
    end

endmodule

// File: rtl/mips_mem_wb_stage.sv
// MEM and WB stages of pipe_MIPS32: data memory, MEM/WB latch, register commit
// and the sticky HALTED / address-error state.
module mips_mem_wb_stage
    import mips_pkg::*;
#(
    parameter int DMEM_DEPTH = 1024,
    parameter int AW         = 10
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          ex_mem_valid,
    input  logic [2:0]    ex_mem_type,
    input  logic [31:0]   ex_mem_ir,
    input  logic [31:0]   ex_mem_aluout,
    input  logic [31:0]   ex_mem_b,
    input  logic          ex_mem_squash,
    input  logic [4:0]    rs_addr,
    input  logic [4:0]    rt_addr,
    output logic [31:0]   rs_data,
    output logic [31:0]   rt_data,
    input  logic          dbg_we,
    input  logic [AW-1:0] dbg_addr,
    input  logic [31:0]   dbg_wdata,
    output logic [31:0]   dbg_rdata,
    output logic          wb_we,
    output logic [4:0]    wb_addr,
    output logic [31:0]   wb_data,
    output logic          halted,
    output logic          addr_err
);

    localparam logic [31:0] DEPTH_W = 32'(DMEM_DEPTH);

    logic [31:0] dmem_r [DMEM_DEPTH];

    logic        mem_wb_valid_r;
    logic [2:0]  mem_wb_type_r;
    logic [31:0] mem_wb_ir_r;
    logic [31:0] mem_wb_aluout_r;
    logic [31:0] mem_wb_lmd_r;
    logic        halted_r;
    logic        addr_err_r;
    logic        wb_we_r;
    logic [4:0]  wb_addr_r;
    logic [31:0] wb_data_r;

    logic        halt_commit_s;
    logic        live_s;
    logic        mem_op_s;
    logic        addr_oob_s;
    logic        store_en_s;
    logic        rf_we_s;
    logic [4:0]  rf_waddr_s;
    logic [31:0] rf_wdata_s;

    // Accept qualification and WB write-port decode.
    always_comb begin
        halt_commit_s = mem_wb_valid_r && is_halt(mem_wb_type_r);
        // An instruction entering MEM on the edge HALT retires is dropped.
        live_s        = ex_mem_valid && !ex_mem_squash && !halted_r && !halt_commit_s;
        mem_op_s      = (ex_mem_type == TYPE_LOAD) || (ex_mem_type == TYPE_STORE);
        addr_oob_s    = (ex_mem_aluout >= DEPTH_W);
        store_en_s    = live_s && (ex_mem_type == TYPE_STORE) && !addr_oob_s;
        rf_waddr_s    = dest_reg(mem_wb_type_r, mem_wb_ir_r);
        rf_we_s       = mem_wb_valid_r && writes_reg(mem_wb_type_r) && (rf_waddr_s != 5'd0);
        if (mem_wb_type_r == TYPE_LOAD) begin
            rf_wdata_s = mem_wb_lmd_r;
        end else begin
            rf_wdata_s = mem_wb_aluout_r;
        end
    end

    // Data memory: debug write first so a same-address pipeline store overrides it.
    always_ff @(posedge clk) begin
        if (dbg_we) begin
            dmem_r[dbg_addr] <= dbg_wdata;
        end
        if (store_en_s) begin
            dmem_r[ex_mem_aluout[AW-1:0]] <= ex_mem_b;
        end
    end

    // MEM/WB latch, commit outputs and sticky status flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_wb_valid_r  <= 1'b0;
            mem_wb_type_r   <= 3'd0;
            mem_wb_ir_r     <= 32'd0;
            mem_wb_aluout_r <= 32'd0;
            mem_wb_lmd_r    <= 32'd0;
            halted_r        <= 1'b0;
            addr_err_r      <= 1'b0;
            wb_we_r         <= 1'b0;
            wb_addr_r       <= 5'd0;
            wb_data_r       <= 32'd0;
        end else begin
            mem_wb_valid_r  <= live_s;
            mem_wb_type_r   <= ex_mem_type;
            mem_wb_ir_r     <= ex_mem_ir;
            mem_wb_aluout_r <= ex_mem_aluout;
            if (live_s && (ex_mem_type == TYPE_LOAD) && !addr_oob_s) begin
                mem_wb_lmd_r <= dmem_r[ex_mem_aluout[AW-1:0]];
            end else begin
                mem_wb_lmd_r <= 32'd0;
            end
            if (live_s && mem_op_s && addr_oob_s) begin
                addr_err_r <= 1'b1;
            end
            if (halt_commit_s) begin
                halted_r <= 1'b1;
            end
            wb_we_r   <= rf_we_s;
            wb_addr_r <= rf_waddr_s;
            wb_data_r <= rf_wdata_s;
        end
    end

    mips_regfile u_regfile (
        .clk     (clk),
        .rst_n   (rst_n),
        .we      (rf_we_s),
        .waddr   (rf_waddr_s),
        .wdata   (rf_wdata_s),
        .raddr_a (rs_addr),
        .rdata_a (rs_data),
        .raddr_b (rt_addr),
        .rdata_b (rt_data)
    );

    assign dbg_rdata = dmem_r[dbg_addr];
    assign wb_we     = wb_we_r;
    assign wb_addr   = wb_addr_r;
    assign wb_data   = wb_data_r;
    assign halted    = halted_r;
    assign addr_err  = addr_err_r;

endmodule

// File: tb/tb_mips_mem_wb_stage.sv
// Directed bench for mips_mem_wb_stage: one task per scenario, inline checks.
module tb_mips_mem_wb_stage;
    import mips_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        ex_mem_valid = 1'b0;
    logic [2:0]  ex_mem_type = 3'd0;
    logic [31:0] ex_mem_ir = 32'd0;
    logic [31:0] ex_mem_aluout = 32'd0;
    logic [31:0] ex_mem_b = 32'd0;
    logic        ex_mem_squash = 1'b0;
    logic [4:0]  rs_addr = 5'd0;
    logic [4:0]  rt_addr = 5'd0;
    logic [31:0] rs_data;
    logic [31:0] rt_data;
    logic        dbg_we = 1'b0;
    logic [9:0]  dbg_addr = 10'd0;
    logic [31:0] dbg_wdata = 32'd0;
    logic [31:0] dbg_rdata;
    logic        wb_we;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;
    logic        halted;
    logic        addr_err;

    int errors = 0;
    int checks = 0;

    mips_mem_wb_stage #(.DMEM_DEPTH(1024), .AW(10)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .ex_mem_valid  (ex_mem_valid),
        .ex_mem_type   (ex_mem_type),
        .ex_mem_ir     (ex_mem_ir),
        .ex_mem_aluout (ex_mem_aluout),
        .ex_mem_b      (ex_mem_b),
        .ex_mem_squash (ex_mem_squash),
        .rs_addr       (rs_addr),
        .rt_addr       (rt_addr),
        .rs_data       (rs_data),
        .rt_data       (rt_data),
        .dbg_we        (dbg_we),
        .dbg_addr      (dbg_addr),
        .dbg_wdata     (dbg_wdata),
        .dbg_rdata     (dbg_rdata),
        .wb_we         (wb_we),
        .wb_addr       (wb_addr),
        .wb_data       (wb_data),
        .halted        (halted),
        .addr_err      (addr_err)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mk_rr(input logic [4:0] rd);
        return {OP_ADD, 5'd1, 5'd2, rd, 11'd0};
    endfunction

    function automatic logic [31:0] mk_i(input logic [5:0] op, input logic [4:0] rt);
        return {op, 5'd1, rt, 16'd0};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [2:0] typ, input logic [31:0] ir,
                         input logic [31:0] alu, input logic [31:0] b, input logic sq);
        ex_mem_valid  = 1'b1;
        ex_mem_type   = typ;
        ex_mem_ir     = ir;
        ex_mem_aluout = alu;
        ex_mem_b      = b;
        ex_mem_squash = sq;
    endtask

    task automatic idle();
        ex_mem_valid  = 1'b0;
        ex_mem_squash = 1'b0;
    endtask

    task automatic dbg_write(input logic [9:0] a, input logic [31:0] d);
        dbg_we = 1'b1; dbg_addr = a; dbg_wdata = d;
        step();
        dbg_we = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        rs_addr = 5'd3;
        #2;
        checks++;
        if ({wb_we, halted, addr_err} !== 3'b000) begin
            errors++; $display("FAIL reset_flags: got %b expected 000", {wb_we, halted, addr_err});
        end
        checks++;
        if (rs_data !== 32'd0) begin
            errors++; $display("FAIL reset_reg: got %h expected 00000000", rs_data);
        end
        step();
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_rr_alu();
        issue(TYPE_RR_ALU, mk_rr(5'd3), 32'h0000_0014, 32'd0, 1'b0);
        step();
        idle();
        step();
        checks++;
        if ({wb_we, wb_addr, wb_data} !== {1'b1, 5'd3, 32'h14}) begin
            errors++; $display("FAIL rr_commit: got we=%b addr=%0d data=%h expected we=1 addr=3 data=00000014", wb_we, wb_addr, wb_data);
        end
        rs_addr = 5'd3;
        #1;
        checks++;
        if (rs_data !== 32'h14) begin
            errors++; $display("FAIL rr_readback: got %h expected 00000014", rs_data);
        end
    endtask

    task automatic test_load_store();
        dbg_write(10'd120, 32'hDEAD_BEEF);
        issue(TYPE_LOAD, mk_i(OP_LW, 5'd5), 32'd120, 32'd0, 1'b0);
        step();
        idle();
        step();
        rt_addr = 5'd5;
        #1;
        checks++;
        if ({wb_we, wb_addr, wb_data, rt_data} !== {1'b1, 5'd5, 32'hDEAD_BEEF, 32'hDEAD_BEEF}) begin
            errors++; $display("FAIL load: got we=%b addr=%0d data=%h rt=%h expected 1/5/deadbeef/deadbeef", wb_we, wb_addr, wb_data, rt_data);
        end
        issue(TYPE_STORE, mk_i(OP_SW, 5'd6), 32'd121, 32'h55, 1'b0);
        step();
        idle();
        dbg_addr = 10'd121;
        #1;
        checks++;
        if (dbg_rdata !== 32'h55) begin
            errors++; $display("FAIL store_visible: got %h expected 00000055", dbg_rdata);
        end
        step();
        checks++;
        if (wb_we !== 1'b0) begin
            errors++; $display("FAIL store_no_wb: got %b expected 0", wb_we);
        end
    endtask

    task automatic test_r0_and_bypass();
        issue(TYPE_RM_ALU, mk_i(OP_ADDI, 5'd0), 32'd7, 32'd0, 1'b0);
        step();
        idle();
        step();
        rs_addr = 5'd0;
        #1;
        checks++;
        if ({wb_we, rs_data} !== {1'b0, 32'd0}) begin
            errors++; $display("FAIL r0_write: got we=%b rs=%h expected we=0 rs=00000000", wb_we, rs_data);
        end
        issue(TYPE_RR_ALU, mk_rr(5'd4), 32'd9, 32'd0, 1'b0);
        step();
        idle();
        rs_addr = 5'd4;
        #1;
        checks++;
        if (rs_data !== 32'd9) begin
            errors++; $display("FAIL bypass: got %h expected 00000009", rs_data);
        end
        step();
        checks++;
        if ({wb_we, wb_addr, rs_data} !== {1'b1, 5'd4, 32'd9}) begin
            errors++; $display("FAIL r4_commit: got we=%b addr=%0d rs=%h expected 1/4/00000009", wb_we, wb_addr, rs_data);
        end
    endtask

    task automatic test_squash_and_addr_err();
        dbg_write(10'd10, 32'h1234_5678);
        issue(TYPE_STORE, mk_i(OP_SW, 5'd6), 32'd10, 32'd1, 1'b1);
        step();
        idle();
        step();
        dbg_addr = 10'd10;
        #1;
        checks++;
        if ({wb_we, dbg_rdata} !== {1'b0, 32'h1234_5678}) begin
            errors++; $display("FAIL squash: got we=%b mem=%h expected we=0 mem=12345678", wb_we, dbg_rdata);
        end
        issue(TYPE_RM_ALU, mk_i(OP_ADDI, 5'd6), 32'h66, 32'd0, 1'b0);
        step();
        issue(TYPE_LOAD, mk_i(OP_LW, 5'd6), 32'd2000, 32'd0, 1'b0);
        step();
        idle();
        checks++;
        if (addr_err !== 1'b1) begin
            errors++; $display("FAIL addr_err_set: got %b expected 1", addr_err);
        end
        step();
        rs_addr = 5'd6;
        #1;
        checks++;
        if ({wb_we, wb_addr, wb_data, rs_data} !== {1'b1, 5'd6, 32'd0, 32'd0}) begin
            errors++; $display("FAIL oob_load: got we=%b addr=%0d data=%h rs=%h expected 1/6/0/0", wb_we, wb_addr, wb_data, rs_data);
        end
        issue(TYPE_RR_ALU, mk_rr(5'd9), 32'd1, 32'd0, 1'b0);
        step();
        idle();
        step();
        checks++;
        if (addr_err !== 1'b1) begin
            errors++; $display("FAIL addr_err_sticky: got %b expected 1", addr_err);
        end
    endtask

    task automatic test_simultaneous();
        issue(TYPE_STORE, mk_i(OP_SW, 5'd6), 32'd30, 32'hA, 1'b0);
        dbg_we = 1'b1; dbg_addr = 10'd30; dbg_wdata = 32'hB;
        step();
        dbg_we = 1'b0;
        idle();
        #1;
        checks++;
        if (dbg_rdata !== 32'hA) begin
            errors++; $display("FAIL same_addr_store: got %h expected 0000000a", dbg_rdata);
        end
        issue(TYPE_STORE, mk_i(OP_SW, 5'd6), 32'd31, 32'h1, 1'b0);
        dbg_we = 1'b1; dbg_addr = 10'd32; dbg_wdata = 32'h2;
        step();
        dbg_we = 1'b0;
        idle();
        #1;
        checks++;
        if (dbg_rdata !== 32'h2) begin
            errors++; $display("FAIL diff_addr_dbg: got %h expected 00000002", dbg_rdata);
        end
        dbg_addr = 10'd31;
        #1;
        checks++;
        if (dbg_rdata !== 32'h1) begin
            errors++; $display("FAIL diff_addr_pipe: got %h expected 00000001", dbg_rdata);
        end
    endtask

    task automatic test_back_to_back();
        dbg_write(10'd40, 32'h40);
        issue(TYPE_LOAD, mk_i(OP_LW, 5'd7), 32'd40, 32'd0, 1'b0);
        step();
        issue(TYPE_STORE, mk_i(OP_SW, 5'd7), 32'd40, 32'h99, 1'b0);
        step();
        idle();
        dbg_addr = 10'd40;
        #1;
        checks++;
        if ({wb_we, wb_addr, wb_data, dbg_rdata} !== {1'b1, 5'd7, 32'h40, 32'h99}) begin
            errors++; $display("FAIL load_then_store: got we=%b addr=%0d data=%h mem=%h expected 1/7/00000040/00000099", wb_we, wb_addr, wb_data, dbg_rdata);
        end
        step();
    endtask

    task automatic test_halt();
        dbg_write(10'd5, 32'h11);
        issue(TYPE_HALT, {OP_HLT, 26'd0}, 32'd0, 32'd0, 1'b0);
        step();
        issue(TYPE_STORE, mk_i(OP_SW, 5'd6), 32'd5, 32'h77, 1'b0);
        step();
        idle();
        dbg_addr = 10'd5;
        #1;
        checks++;
        if ({halted, wb_we, dbg_rdata} !== {1'b1, 1'b0, 32'h11}) begin
            errors++; $display("FAIL halt_drop: got halted=%b we=%b mem=%h expected 1/0/00000011", halted, wb_we, dbg_rdata);
        end
        step();
        checks++;
        if (dbg_rdata !== 32'h11) begin
            errors++; $display("FAIL halt_store_late: got %h expected 00000011", dbg_rdata);
        end
        issue(TYPE_RR_ALU, mk_rr(5'd8), 32'h88, 32'd0, 1'b0);
        step();
        step();
        rs_addr = 5'd8;
        rt_addr = 5'd3;
        #1;
        checks++;
        if ({wb_we, rs_data, rt_data, halted} !== {1'b0, 32'd0, 32'h14, 1'b1}) begin
            errors++; $display("FAIL halted_ignore: got we=%b rs=%h rt=%h halted=%b expected 0/0/00000014/1", wb_we, rs_data, rt_data, halted);
        end
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({halted, addr_err, wb_we, rt_data} !== {1'b0, 1'b0, 1'b0, 32'd0}) begin
            errors++; $display("FAIL async_reset: got halted=%b err=%b we=%b rt=%h expected 0/0/0/0", halted, addr_err, wb_we, rt_data);
        end
        idle();
        step();
        rst_n = 1'b1;
        step();
    endtask

    initial begin
        test_reset();
        test_rr_alu();
        test_load_store();
        test_r0_and_bypass();
        test_squash_and_addr_err();
        test_simultaneous();
        test_back_to_back();
        test_halt();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
